// File: rtl/npu_argmax_scanner.sv
// Scans N consecutive O_buf entries and reports the index and value of the largest
// signed entry; the lowest index wins ties.
module npu_argmax_scanner #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_N    = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  input  logic [$clog2(ARRAY_N):0]      num_cols_i,
  output logic                          rd_en_o,
  output logic [ADDR_WIDTH-1:0]         rd_addr_o,
  input  logic signed [DATA_WIDTH-1:0]  rd_data_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [$clog2(ARRAY_N)-1:0]    max_idx_o,
  output logic signed [DATA_WIDTH-1:0]  max_val_o
);

  localparam int CNT_W = $clog2(ARRAY_N) + 1;
  localparam int IDX_W = $clog2(ARRAY_N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic [CNT_W-1:0] clamp_cols(input logic [CNT_W-1:0] cols);
    return (cols > CNT_W'(ARRAY_N)) ? CNT_W'(ARRAY_N) : cols;
  endfunction

  logic [1:0]                   state_q;
  logic [CNT_W-1:0]             n_q;
  logic [IDX_W-1:0]             issue_cnt_q;
  logic [ADDR_WIDTH-1:0]        rd_addr_q;
  logic                         vld_p1;
  logic [IDX_W-1:0]             data_cnt_p1;
  logic signed [DATA_WIDTH-1:0] run_max_q;
  logic [IDX_W-1:0]             run_idx_q;
  logic signed [DATA_WIDTH-1:0] max_val_q;
  logic [IDX_W-1:0]             max_idx_q;

  logic                         start_ok;
  logic [CNT_W-1:0]             n_start;
  logic                         last_issue;
  logic                         take_p1;
  logic signed [DATA_WIDTH-1:0] nxt_max;
  logic [IDX_W-1:0]             nxt_idx;

  assign start_ok   = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign n_start    = clamp_cols(num_cols_i);
  assign last_issue = (state_q == S_READ) && ({1'b0, issue_cnt_q} == (n_q - CNT_W'(1)));

  // Stage p1: datum returned for the read issued last cycle, compared against the running max
  assign take_p1 = vld_p1 && (rd_data_i > run_max_q);
  assign nxt_max = take_p1 ? rd_data_i : run_max_q;
  assign nxt_idx = take_p1 ? data_cnt_p1 : run_idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      issue_cnt_q <= '0;
      rd_addr_q   <= '0;
      vld_p1      <= 1'b0;
      data_cnt_p1 <= '0;
      run_max_q   <= MOST_NEG;
      run_idx_q   <= '0;
      max_val_q   <= '0;
      max_idx_q   <= '0;
    end else begin
      vld_p1      <= (state_q == S_READ);
      data_cnt_p1 <= issue_cnt_q;
      run_max_q   <= nxt_max;
      run_idx_q   <= nxt_idx;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            n_q         <= n_start;
            issue_cnt_q <= '0;
            run_max_q   <= MOST_NEG;
            run_idx_q   <= '0;
            if (n_start == '0) begin
              state_q   <= S_DONE;
              max_val_q <= MOST_NEG;
              max_idx_q <= '0;
            end else begin
              state_q   <= S_READ;
              rd_addr_q <= base_addr_i;
            end
          end
        end
        S_READ: begin
          if (last_issue) begin
            state_q <= S_LAST;
          end else begin
            issue_cnt_q <= issue_cnt_q + IDX_W'(1);
            rd_addr_q   <= rd_addr_q + ADDR_WIDTH'(1);
          end
        end
        S_LAST: begin
          state_q   <= S_DONE;
          max_val_q <= nxt_max;
          max_idx_q <= nxt_idx;
        end
      endcase
    end
  end

  assign rd_en_o   = (state_q == S_READ);
  assign rd_addr_o = rd_addr_q;
  assign busy_o    = (state_q == S_READ) || (state_q == S_LAST);
  assign done_o    = (state_q == S_DONE);
  assign max_idx_o = max_idx_q;
  assign max_val_o = max_val_q;

endmodule

// File: tb/tb_npu_argmax_scanner.sv
// Directed bench for npu_argmax_scanner: a small O_buf model with one-cycle read latency
// and hand-computed expected index/value/latency per scan.
module tb_npu_argmax_scanner;

  logic              clk_i;
  logic              rst_ni;
  logic              start_i;
  logic [31:0]       base_addr_i;
  logic [4:0]        num_cols_i;
  logic              rd_en_o;
  logic [31:0]       rd_addr_o;
  logic signed [7:0] rd_data_i;
  logic              busy_o;
  logic              done_o;
  logic [3:0]        max_idx_o;
  logic signed [7:0] max_val_o;

  logic signed [7:0] mem [0:255];

  int n_checks = 0;
  int n_pass   = 0;

  npu_argmax_scanner #(
    .DATA_WIDTH(8),
    .ARRAY_N   (16),
    .ADDR_WIDTH(32)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .num_cols_i (num_cols_i),
    .rd_en_o    (rd_en_o),
    .rd_addr_o  (rd_addr_o),
    .rd_data_i  (rd_data_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .max_idx_o  (max_idx_o),
    .max_val_o  (max_val_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (rd_en_o) rd_data_i <= mem[rd_addr_o[7:0]];
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // done latency counts clock edges after the accepting edge; 0 means done at that edge
  task automatic run_scan(input string tag, input logic [31:0] base, input int ncols,
                          input int exp_reads, input int exp_idx, input int exp_val,
                          input int exp_lat, input int poke_at);
    int lat, reads, addr_err, hold_err, post_err, prev_idx, prev_val;
    prev_idx = int'(max_idx_o);
    prev_val = int'(max_val_o);
    start_i     = 1'b1;
    base_addr_i = base;
    num_cols_i  = 5'(ncols);
    @(negedge clk_i);
    start_i     = 1'b0;
    base_addr_i = 32'h0;
    num_cols_i  = 5'd0;
    lat = 0; reads = 0; addr_err = 0; hold_err = 0; post_err = 0;
    while (!done_o && lat < 40) begin
      if (rd_en_o) begin
        if (rd_addr_o !== base + 32'(reads)) addr_err++;
        reads++;
      end
      if (int'(max_idx_o) != prev_idx || int'(max_val_o) != prev_val) hold_err++;
      if (lat == poke_at) begin
        start_i     = 1'b1;
        num_cols_i  = 5'd2;
        base_addr_i = 32'h0;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      lat++;
    end
    start_i = 1'b0;
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".reads"}, reads, exp_reads);
    check({tag, ".addr_seq_errors"}, addr_err, 0);
    check({tag, ".result_hold_errors"}, hold_err, 0);
    check({tag, ".max_idx"}, int'(max_idx_o), exp_idx);
    check({tag, ".max_val"}, int'(max_val_o), exp_val);
    check({tag, ".busy"}, int'(busy_o), 0);
    repeat (3) begin
      @(negedge clk_i);
      if (!done_o || rd_en_o) post_err++;
    end
    check({tag, ".done_hold"}, post_err, 0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    base_addr_i = 32'h0;
    num_cols_i  = 5'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'sd0;
    for (int i = 0; i < 16; i++) mem[8'h10 + i] = 8'(i - 8);
    mem[8'h40] = 8'sd3;  mem[8'h41] = -8'sd1; mem[8'h42] = 8'sd9;
    mem[8'h43] = 8'sd9;  mem[8'h44] = 8'sd2;
    for (int i = 0; i < 16; i++) mem[8'h80 + i] = -8'sd128;
    for (int i = 0; i < 16; i++) mem[8'hA0 + i] = 8'(i * 3);
    for (int i = 16; i < 20; i++) mem[8'hA0 + i] = 8'sd120;
    for (int i = 0; i < 16; i++) mem[8'hC0 + i] = 8'sd1;
    mem[8'hC4] = 8'sd100;

    @(negedge clk_i);
    check("reset.done", int'(done_o), 0);
    check("reset.busy", int'(busy_o), 0);
    check("reset.rd_en", int'(rd_en_o), 0);
    check("reset.max_idx", int'(max_idx_o), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_scan("ramp16", 32'h10, 16, 16, 15, 7, 17, -1);
    run_scan("tie10", 32'h40, 10, 10, 2, 9, 11, -1);
    run_scan("zero_cols", 32'h40, 0, 0, 0, -128, 0, -1);
    run_scan("all_min", 32'h80, 16, 16, 0, -128, 17, -1);
    run_scan("clamp20_poke", 32'hA0, 20, 16, 15, 45, 17, 5);

    // asynchronous reset in the middle of a scan
    start_i     = 1'b1;
    base_addr_i = 32'hC0;
    num_cols_i  = 5'd16;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("midscan.busy_before", int'(busy_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    check("midscan_rst.rd_en", int'(rd_en_o), 0);
    check("midscan_rst.rd_addr", int'(rd_addr_o), 0);
    check("midscan_rst.busy", int'(busy_o), 0);
    check("midscan_rst.done", int'(done_o), 0);
    check("midscan_rst.max_idx", int'(max_idx_o), 0);
    check("midscan_rst.max_val", int'(max_val_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_scan("rst_rescan", 32'hC0, 16, 16, 4, 100, 17, -1);

    run_scan("from_done", 32'h10, 16, 16, 15, 7, 17, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
